gate_key_sender: RTL
====================

# gate_key_sender

Byte-serial key transmitter that drives the sequence-checker gate from the other end of its interface. It holds a key of up to DEPTH bytes, clears the checker, streams the key one byte per clock with no gaps, then samples the checker's GOOD line. It reports pass or fail to a host controller. It sits between the host/test controller and any checker that consumes one BYTE per CLK with an active-low reset.

## Interface
- DEPTH, 32: key buffer capacity in bytes, ≥1; AW = $clog2(DEPTH), LW = $clog2(DEPTH+1)
- GOOD_LAT, 1: cycles from the last key byte's clock edge to the cycle in which GOOD is valid, ≥1
- IDLE_BYTE, 8'h00: value driven on BYTE whenever no key byte is being sent
- CLK  in  1  sole clock, rising edge
- RESET  in  1  synchronous reset, active-high
- WR_EN  in  1  key buffer write strobe, honoured only in IDLE
- WR_ADDR  in  AW  key buffer write address
- WR_DATA  in  8  key byte
- LEN  in  LW  key length, sampled with START; values above DEPTH are clamped to DEPTH
- START  in  1  begin a transaction, honoured only in IDLE
- ABORT  in  1  cancel the transaction in progress
- GOOD  in  1  checker verdict
- BYTE  out  8  byte stream to the checker
- BYTE_VALID  out  1  high while BYTE carries a key byte
- CHK_RESET_N  out  1  checker reset, active-low
- BUSY  out  1  transaction in progress
- DONE  out  1  one-cycle completion pulse
- PASS  out  1  verdict of the last completed transaction, held until the next START

## Operation
- FSM states: IDLE, CLEAR, SEND, WAIT, FINISH.
- IDLE
  - BUSY=0, BYTE=IDLE_BYTE, CHK_RESET_N=1.
  - WR_EN writes WR_DATA to buf[WR_ADDR].
  - START latches min(LEN, DEPTH) into len_q and clears PASS.
  - If len_q=0, go to FINISH with verdict 0 and no checker activity. Otherwise go to CLEAR.
- CLEAR: one cycle, CHK_RESET_N=0, BYTE=IDLE_BYTE. Go to SEND, idx=0.
- SEND
  - BYTE=buf[idx], BYTE_VALID=1, idx increments each cycle.
  - Stays in SEND for exactly len_q contiguous cycles. The checker has no valid input, so no bubbles are permitted.
- WAIT
  - BYTE=IDLE_BYTE, lasts GOOD_LAT cycles.
  - GOOD is sampled on the final WAIT cycle's edge into the verdict.
- FINISH: one cycle, DONE=1, PASS=verdict, BUSY=0 the following cycle. Returns to IDLE.
- BUSY is 1 in CLEAR, SEND, WAIT and FINISH.
- Writes while BUSY are dropped. START while BUSY is ignored.
- ABORT in any non-IDLE state:
  - Next state is IDLE, with no DONE and PASS=0.
  - CHK_RESET_N=0 for that one ABORT-following cycle, so the checker never holds partial state.
  - ABORT has priority over all transitions.
- Simultaneous START and ABORT in IDLE: START wins, and ABORT is ignored.
- The key buffer is not cleared by RESET.

## Timing
- Reset values: FSM state IDLE, idx=0.
  - BYTE=IDLE_BYTE, BYTE_VALID=0, CHK_RESET_N=1.
  - BUSY=0, DONE=0, PASS=0.
- RESET mid-transaction returns to IDLE on the next edge; no DONE is produced.
- START sampled at edge of cycle 0. Then:
  - Cycle 1: CLEAR.
  - Cycles 2..L+1: SEND.
  - Cycles L+2..L+1+GOOD_LAT: WAIT.
  - Cycle L+2+GOOD_LAT: DONE=1.
- Total START-to-DONE latency is L+2+GOOD_LAT cycles.
- All outputs are registered. BYTE for SEND cycle k is buf[k] as it stood when START was sampled, because the buffer is frozen while BUSY.
- idx never wraps, since len_q ≤ DEPTH. With len_q=DEPTH the last address is DEPTH-1.
- LEN=0: DONE is raised 1 cycle after START, with PASS=0.

## Structure
- Package gate_pkg holds:
  - the state enum: IDLE, CLEAR, SEND, WAIT, FINISH;
  - the default IDLE_BYTE constant;
  - the byte typedef.
- Sub-module gate_key_buf: DEPTH×8 storage with synchronous write and combinational read, with the read feeding the BYTE register.
- The top level holds the FSM, idx/len_q/WAIT counters and the output registers.

## Test plan
- Basic pass
  - Stimulus: load "ABC" (8'h41, 8'h42, 8'h43), LEN=3, GOOD_LAT=1, and a checker model accepting "ABC".
  - Required response:
    - CHK_RESET_N low in cycle 1.
    - BYTE 41/42/43 in cycles 2–4.
    - DONE in cycle 6 with PASS=1.
- Wrong key
  - Stimulus: load "ABD" with the same checker model.
  - Required response: DONE in cycle 6 with PASS=0, and no gaps in BYTE_VALID.
- Boundary lengths
  - Stimulus: LEN=0, then LEN=DEPTH+5.
  - Required response:
    - LEN=0: DONE one cycle after START, PASS=0, CHK_RESET_N never low.
    - LEN=DEPTH+5: exactly DEPTH bytes sent.
- ABORT during SEND
  - Stimulus: assert ABORT on the 2nd key byte.
  - Required response: no DONE, PASS=0, CHK_RESET_N low for one cycle, then IDLE.
- RESET during WAIT
  - Stimulus: assert RESET during WAIT.
  - Required response: all outputs return to their reset values, and the buffer contents survive (a re-run passes).
- Ignored inputs while BUSY
  - Stimulus: issue WR_EN and START while BUSY.
  - Required response: streamed bytes are unchanged, and no second transaction starts.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared types and constants for the gate key sender.
//   state_e         : transaction FSM states
//   byte_t          : one key / stream byte
//   IdleByteDefault : default filler driven on the byte stream when no key byte is sent
package gate_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t IdleByteDefault = 8'h00;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StSend,
    StWait,
    StFinish
  } state_e;

endpackage

// File: rtl/gate_key_buf.sv
// Key byte storage: DEPTH x 8, synchronous write, combinational read.
//   i_clk     : clock
//   i_wr_en   : write strobe (already qualified by the caller)
//   i_wr_addr : write address
//   i_wr_data : byte to store
//   i_rd_addr : read address
//   o_rd_data : byte at i_rd_addr
module gate_key_buf
  import gate_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  // No reset: key contents must survive a controller reset.
  byte_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/gate_key_sender.sv
// Byte-serial key transmitter: clears a downstream checker, streams a stored key one byte per
// clock without gaps, samples the checker's verdict and reports it to the host.
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_wr_en/addr/data    : key buffer write port (IDLE only)
//   i_len, i_start       : key length (clamped to DEPTH) and transaction start (IDLE only)
//   i_abort              : cancel the running transaction
//   i_good               : checker verdict
//   o_byte, o_byte_valid : stream to the checker and key-byte qualifier
//   o_chk_reset_n        : checker reset, active-low
//   o_busy, o_done, o_pass : status, completion pulse, held verdict
module gate_key_sender
  import gate_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned GOOD_LAT  = 1,
  parameter logic [7:0]  IDLE_BYTE = IdleByteDefault,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LW = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [LW-1:0] i_len,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_good,
  output logic [7:0]    o_byte,
  output logic          o_byte_valid,
  output logic          o_chk_reset_n,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass
);

  localparam int unsigned WW = (GOOD_LAT > 1) ? $clog2(GOOD_LAT) : 1;

  state_e        r_state, w_state_d;
  logic [LW-1:0] r_len, w_len_d;
  logic [LW-1:0] r_idx, w_idx_d;
  logic [WW-1:0] r_wait, w_wait_d;
  logic [LW-1:0] w_len_clamped;
  logic          w_start_taken, w_abort_taken, w_good_take;
  byte_t         w_rd_data;

  byte_t r_byte;
  logic  r_byte_valid, r_chk_reset_n, r_busy, r_done, r_pass;

  assign w_len_clamped = (i_len > LW'(DEPTH)) ? LW'(DEPTH) : i_len;

  gate_key_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .i_clk     (i_clk),
    .i_wr_en   (i_wr_en && (r_state == StIdle)),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (AW'(w_idx_d)),
    .o_rd_data (w_rd_data)
  );

  // r_idx is the index of the byte currently on o_byte while in SEND; the read port looks
  // one step ahead (w_idx_d) so the registered output lines up with the state.
  always_comb begin
    w_state_d     = r_state;
    w_len_d       = r_len;
    w_idx_d       = r_idx;
    w_wait_d      = r_wait;
    w_start_taken = 1'b0;
    w_abort_taken = 1'b0;
    w_good_take   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_start_taken = 1'b1;
          w_len_d       = w_len_clamped;
          w_state_d     = (w_len_clamped == '0) ? StFinish : StClear;
        end
      end
      StClear: begin
        w_state_d = StSend;
        w_idx_d   = '0;
      end
      StSend: begin
        if (r_idx == r_len - LW'(1)) begin
          w_state_d = StWait;
          w_wait_d  = '0;
        end else begin
          w_idx_d = r_idx + LW'(1);
        end
      end
      StWait: begin
        if (r_wait == WW'(GOOD_LAT - 1)) begin
          w_state_d   = StFinish;
          w_good_take = 1'b1;
        end else begin
          w_wait_d = r_wait + WW'(1);
        end
      end
      StFinish: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
    // Abort overrides every transition out of a busy state.
    if (i_abort && (r_state != StIdle)) begin
      w_abort_taken = 1'b1;
      w_good_take   = 1'b0;
      w_state_d     = StIdle;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_len         <= '0;
      r_idx         <= '0;
      r_wait        <= '0;
      r_byte        <= IDLE_BYTE;
      r_byte_valid  <= 1'b0;
      r_chk_reset_n <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_len         <= w_len_d;
      r_idx         <= w_idx_d;
      r_wait        <= w_wait_d;
      r_byte        <= (w_state_d == StSend) ? w_rd_data : IDLE_BYTE;
      r_byte_valid  <= (w_state_d == StSend);
      r_chk_reset_n <= !((w_state_d == StClear) || w_abort_taken);
      r_busy        <= (w_state_d != StIdle);
      r_done        <= (w_state_d == StFinish);
      if (w_start_taken || w_abort_taken) begin
        r_pass <= 1'b0;
      end else if (w_good_take) begin
        r_pass <= i_good;
      end
    end
  end

  assign o_byte        = r_byte;
  assign o_byte_valid  = r_byte_valid;
  assign o_chk_reset_n = r_chk_reset_n;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_pass        = r_pass;

endmodule
